cpu_run_dump_ctrl: RTL

Synthesizable run/dump controller that sits beside the single-cycle CPU in the lab top level. It enables the CPU for a programmable number of cycles, or until an early halt request, then freezes it. It then streams the first DUMP_REGS register-file entries over a valid/ready interface and reports completion. The stream feeds a UART/trace sink or the bench's result-file writer.

---
 rtl/cpu_dbg_pkg.sv | 17 +
 rtl/dump_skid_reg.sv | 34 +++
 rtl/cpu_run_dump_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared types and defaults for the CPU run/dump debug controller and its helpers.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDump,
        StDone
    } ctrl_state_e;

    localparam int unsigned DefDataW    = 32;
    localparam int unsigned DefNumRegs  = 32;
    localparam int unsigned DefDumpRegs = 13;
    localparam int unsigned DefCntW     = 16;
    localparam int unsigned DefRaddrW   = $clog2(DefNumRegs);

endpackage

// File: rtl/dump_skid_reg.sv
// Valid/ready output register: loads when empty or draining, holds its beat while stalled.
module dump_skid_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_run_dump_ctrl.sv
// Runs the CPU for a bounded number of enabled cycles (or until halt), then streams
// the low register-file entries out over a valid/ready port.
module cpu_run_dump_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter  int unsigned DATA_W    = DefDataW,
    parameter  int unsigned NUM_REGS  = DefNumRegs,
    parameter  int unsigned DUMP_REGS = DefDumpRegs,
    parameter  int unsigned CNT_W     = DefCntW,
    localparam int unsigned RADDR_W   = $clog2(NUM_REGS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   run_cycles_i,
    input  logic               halt_i,
    output logic               cpu_en_o,
    output logic [RADDR_W-1:0] rf_raddr_o,
    input  logic [DATA_W-1:0]  rf_rdata_i,
    output logic               dump_valid_o,
    input  logic               dump_ready_i,
    output logic [RADDR_W-1:0] dump_idx_o,
    output logic [DATA_W-1:0]  dump_data_o,
    output logic [CNT_W-1:0]   cycle_cnt_o,
    output logic               busy_o,
    output logic               done_o
);

    // One extra bit so the pointer can reach DUMP_REGS even when it equals NUM_REGS.
    localparam int unsigned PtrW = RADDR_W + 1;

    ctrl_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cycle_cnt_q;
    logic [CNT_W-1:0]   limit_q;
    logic [PtrW-1:0]    ptr_q;

    logic               start_accept;
    logic               limit_hit;
    logic               load_req;
    logic               load_rdy;
    logic               last_accept;
    logic [RADDR_W+DATA_W-1:0] beat_in;
    logic [RADDR_W+DATA_W-1:0] beat_out;

    assign start_accept = start_i && ((state_q == StIdle) || (state_q == StDone));
    assign limit_hit    = ({1'b0, cycle_cnt_q} + (CNT_W + 1)'(1)) == {1'b0, limit_q};

    assign load_req    = (state_q == StDump) && (ptr_q < PtrW'(DUMP_REGS));
    assign beat_in     = {ptr_q[RADDR_W-1:0], rf_rdata_i};
    assign last_accept = (state_q == StDump) && dump_valid_o && dump_ready_i &&
                         (dump_idx_o == RADDR_W'(DUMP_REGS - 1));

    assign cpu_en_o    = (state_q == StRun);
    assign busy_o      = (state_q == StRun) || (state_q == StDump);
    assign done_o      = (state_q == StDone);
    assign rf_raddr_o  = ptr_q[RADDR_W-1:0];
    assign cycle_cnt_o = cycle_cnt_q;
    assign dump_idx_o  = beat_out[RADDR_W+DATA_W-1:DATA_W];
    assign dump_data_o = beat_out[DATA_W-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = (run_cycles_i == '0) ? StDump : StRun;
                end
            end
            StRun: begin
                if (limit_hit || halt_i) begin
                    state_d = StDump;
                end
            end
            StDump: begin
                if (last_accept) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_q <= '0;
            limit_q     <= '0;
        end else if (start_accept) begin
            cycle_cnt_q <= '0;
            limit_q     <= run_cycles_i;
        end else if (state_q == StRun) begin
            if (!(&cycle_cnt_q)) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || start_accept) begin
            ptr_q <= '0;
        end else if (load_req && load_rdy) begin
            ptr_q <= ptr_q + PtrW'(1);
        end
    end

    dump_skid_reg #(
        .W (RADDR_W + DATA_W)
    ) u_dump_reg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (load_req),
        .in_ready_o  (load_rdy),
        .in_data_i   (beat_in),
        .out_valid_o (dump_valid_o),
        .out_ready_i (dump_ready_i),
        .out_data_o  (beat_out)
    );

endmodule
